// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop rxd synchroniser, mid-bit sampling FSM and a
// one-entry holding register with valid/read handshake, overrun and framing error.
module uart_rx_byte #(
   parameter int unsigned CLK_FREQ = 25000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rx_rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   // CLKS_PER_BIT must be at least 8 for the mid-bit sampling margin to hold.
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W        = 3;
   localparam int unsigned DATA_W       = 8;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                overrun_q, overrun_d;
   logic                frame_err_q, frame_err_d;
   logic                busy_q, busy_d;
   logic                sync1_q, sync2_q;
   logic                rxd_s;
   logic                load_c;

   // Synchroniser resets high so an idle line never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   assign rxd_s = sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;
      load_c      = 1'b0;

      if (rx_rd && rx_valid_q) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!rxd_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rxd_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_TC) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rxd_s;
               bit_idx_d          = bit_idx_q + IDX_W'(1);
               if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_TC) begin
               cnt_d = '0;
               if (rxd_s) begin
                  load_c  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BREAK: begin
            if (rxd_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A load beats a same-cycle read; overrun only when the old byte was unread.
      if (load_c) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rx_rd) begin
            overrun_d = 1'b1;
         end
      end
   end

   assign busy_d = (state_d != ST_IDLE);

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 25 MHz / 115200 baud (217 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_byte;

   localparam int BIT_CLKS = 217;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic       rx_rd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int start_cyc  = 0;
   int rise_cyc   = 0;
   int fe_count   = 0;
   int fe_run     = 0;
   int fe_run_max = 0;
   int lat;
   logic prev_valid = 1'b0;

   uart_rx_byte dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_rd     (rx_rd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observers sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (frame_err === 1'b1) begin
         fe_count = fe_count + 1;
         fe_run   = fe_run + 1;
         if (fe_run > fe_run_max) fe_run_max = fe_run;
      end else begin
         fe_run = 0;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input int extra_start, input logic stop);
      start_cyc = cyc;
      rxd = 1'b0;
      wait_clks(BIT_CLKS + extra_start);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         wait_clks(BIT_CLKS);
      end
      rxd = stop;
      wait_clks(BIT_CLKS);
   endtask

   task automatic read_pulse();
      rx_rd = 1'b1;
      wait_clks(1);
      rx_rd = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      rxd   = 1'b1;
      rx_rd = 1'b0;
      wait_clks(3);
      chk("rst_data", 32'(rx_data), 32'h00);
      chk("rst_valid", 32'(rx_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      wait_clks(2000);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_valid", 32'(rx_valid), 32'h0);

      // Plain 0x09 with latency from the start edge
      send_frame(8'h09, 0, 1'b1);
      chk("b09_data", 32'(rx_data), 32'h09);
      chk("b09_valid", 32'(rx_valid), 32'h1);
      chk("b09_fe", 32'(fe_count), 32'd0);
      lat = rise_cyc - start_cyc;
      n_cmp++;
      assert (lat >= 2063 && lat <= 2065) else begin
         n_fail++;
         $error("FAIL b09_latency: observed %0d expected 2064 +/-1", lat);
      end
      read_pulse();
      chk("b09_rd_valid", 32'(rx_valid), 32'h0);
      chk("b09_rd_data", 32'(rx_data), 32'h09);
      read_pulse();
      chk("idle_rd_valid", 32'(rx_valid), 32'h0);
      chk("idle_rd_overrun", 32'(overrun), 32'h0);

      // Start bit stretched by 25 cycles
      send_frame(8'h09, 25, 1'b1);
      chk("skew_data", 32'(rx_data), 32'h09);
      chk("skew_valid", 32'(rx_valid), 32'h1);
      chk("skew_fe", 32'(fe_count), 32'd0);
      read_pulse();

      // Back-to-back without a read: overrun
      send_frame(8'h55, 0, 1'b1);
      chk("b55_data", 32'(rx_data), 32'h55);
      chk("b55_overrun", 32'(overrun), 32'h0);
      send_frame(8'hA5, 0, 1'b1);
      chk("bA5_data", 32'(rx_data), 32'hA5);
      chk("bA5_valid", 32'(rx_valid), 32'h1);
      chk("bA5_overrun", 32'(overrun), 32'h1);
      read_pulse();
      chk("ovr_rd_valid", 32'(rx_valid), 32'h0);
      chk("ovr_rd_overrun", 32'(overrun), 32'h0);

      // 40-cycle low glitch is rejected at half-bit
      rxd = 1'b0;
      wait_clks(10);
      chk("glitch_busy_hi", 32'(busy), 32'h1);
      wait_clks(30);
      rxd = 1'b1;
      wait_clks(200);
      chk("glitch_busy_lo", 32'(busy), 32'h0);
      chk("glitch_valid", 32'(rx_valid), 32'h0);
      chk("glitch_fe", 32'(fe_count), 32'd0);

      // Framing error then held-low break
      send_frame(8'h3C, 0, 1'b0);
      wait_clks(500);
      chk("fe_count", 32'(fe_count), 32'd1);
      chk("fe_width", 32'(fe_run_max), 32'd1);
      chk("fe_valid", 32'(rx_valid), 32'h0);
      chk("fe_data_held", 32'(rx_data), 32'hA5);
      chk("break_busy", 32'(busy), 32'h1);
      rxd = 1'b1;
      wait_clks(5);
      chk("break_release", 32'(busy), 32'h0);
      send_frame(8'h81, 0, 1'b1);
      chk("b81_data", 32'(rx_data), 32'h81);
      chk("b81_valid", 32'(rx_valid), 32'h1);
      chk("b81_fe", 32'(fe_count), 32'd1);
      read_pulse();
      chk("b81_rd_valid", 32'(rx_valid), 32'h0);

      // Reset during bit 4 of 0xF0
      rxd = 1'b0;
      wait_clks(BIT_CLKS * 5);
      rxd = 1'b1;
      wait_clks(100);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      wait_clks(2);
      chk("mid_rst_data", 32'(rx_data), 32'h00);
      chk("mid_rst_valid", 32'(rx_valid), 32'h0);
      chk("mid_rst_overrun", 32'(overrun), 32'h0);
      chk("mid_rst_fe", 32'(frame_err), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      wait_clks(3);
      reset = 1'b0;
      wait_clks(300);
      chk("post_rst_busy", 32'(busy), 32'h0);
      send_frame(8'h12, 0, 1'b1);
      chk("b12_data", 32'(rx_data), 32'h12);
      chk("b12_valid", 32'(rx_valid), 32'h1);
      chk("b12_overrun", 32'(overrun), 32'h0);

      // Read strobe lands in the exact load cycle of 0x77
      fork
         send_frame(8'h77, 0, 1'b1);
         begin
            wait_clks(2063);
            rx_rd = 1'b1;
            wait_clks(1);
            rx_rd = 1'b0;
         end
      join
      chk("sim_data", 32'(rx_data), 32'h77);
      chk("sim_valid", 32'(rx_valid), 32'h1);
      chk("sim_overrun", 32'(overrun), 32'h0);
      read_pulse();
      chk("final_valid", 32'(rx_valid), 32'h0);
      chk("final_fe", 32'(fe_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- 8N1 UART receiver for the SOC serial port; drives the RXD-side byte stream into the CPU's memory-mapped UART register.
- Synchronises the asynchronous rxd pin and validates the start bit at half-bit time.
- Samples 8 data bits LSB-first at mid-bit and checks the stop bit.
- Presents each byte in a one-entry holding register with a valid/read handshake, overrun flag and framing-error pulse.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (217), clocks per bit. Derived; must be >= 8.
- HALF_BIT, CLKS_PER_BIT/2 (108), start-bit mid-sample point, integer division.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rx_rd  in  1  single-cycle read strobe from the CPU bus; consumes the held byte.
- rx_data  out  8  last received byte.
- rx_valid  out  1  high while rx_data holds an unread byte.
- overrun  out  1  sticky; a byte arrived while rx_valid was high.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert by design use):
  - rx_data=0x00, rx_valid=0, overrun=0, frame_err=0, busy=0.
  - FSM=IDLE, counters=0.
  - Both synchroniser flops=1, so no false start is seen after reset.
- Synchroniser: rxd passes through 2 flops, giving rxd_s. All decisions use rxd_s only.
- Bit counter: cnt, ceil(log2(CLKS_PER_BIT)) bits. Bit index: 3 bits. Shift register: 8 bits.
- FSM:
  - IDLE: when rxd_s==0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt==HALF_BIT-1:
    - rxd_s==0: go to DATA with cnt=0, bit index=0.
    - rxd_s==1: glitch; return to IDLE with no outputs changed.
  - DATA: cnt counts 0..CLKS_PER_BIT-1. At terminal count, shift rxd_s in at bit[bit index] (LSB first) and reset cnt. After bit 7, go to STOP.
  - STOP: at terminal count, sample rxd_s.
    - 1: load rx_data with the shift register, set rx_valid, go to IDLE on the same edge.
    - 0: pulse frame_err for 1 cycle, discard the byte (rx_data and rx_valid unchanged), go to BREAK.
  - BREAK: wait for rxd_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering.
- Latency: rx_valid rises HALF_BIT + 9*CLKS_PER_BIT + 3 cycles (±1) after the rxd falling edge. For defaults: 2064 ±1 cycles.
- Skew tolerance: mid-bit sampling tolerates up to ±(HALF_BIT-4) cycles of accumulated edge offset. A start bit stretched by 25 cycles must still decode correctly.
- Handshake:
  - rx_rd while rx_valid=1: clears rx_valid and overrun on the next edge. rx_data is held.
  - rx_rd while rx_valid=0: ignored.
- Simultaneous events:
  - Byte load in the same cycle as rx_rd: the load wins. rx_valid stays 1, rx_data takes the new byte, overrun is not set (the old byte was consumed).
  - Byte load with rx_valid=1 and no rx_rd: rx_data is overwritten and overrun is set to 1.
- No back-to-back gap is required: after a stop-bit sample, a new start edge is accepted from the next cycle.
- A reset in any state aborts the byte immediately. After release, the receiver waits for rxd_s==0 in IDLE. A mid-frame tail may be misread as a start bit; this is accepted behaviour.

Test Plan:
- Reset, idle 2000 cycles at 25 MHz, then send 0x09 at 217 clk/bit -> rx_data=0x09, rx_valid=1 at 2064±1 cycles after the start edge, frame_err never 1. Pulse rx_rd -> rx_valid=0 next cycle.
- Send 0x09 with the start bit lengthened by 25 cycles (1000 ns) -> rx_data=0x09, no frame_err.
- Send 0x55 and 0xA5 back-to-back with no rx_rd -> rx_data=0xA5, rx_valid=1, overrun=1. Pulse rx_rd -> rx_valid=0 and overrun=0.
- Drive rxd low for 40 cycles, then high -> busy pulses, returns to IDLE; rx_valid=0, no frame_err.
- Send 0x3C with the stop bit low, hold low 500 cycles, then high -> frame_err one-cycle pulse, rx_valid stays 0, FSM in BREAK until release. A following 0x81 decodes correctly.
- Assert reset at bit 4 of 0xF0, release, then send 0x12 -> all outputs 0 during reset; rx_data=0x12 afterward. Also assert rx_rd in the exact cycle of a load -> rx_valid stays 1, overrun stays 0.
